hc: RTL and testbench
=====================

HC -- requirements
Module: hc

Interface
REQ-001 Parameter T_ON, default 18: signed 8-bit heat-on threshold; heater turns on when the average temperature is strictly below it.
REQ-002 Parameter T_OFF, default 22: signed 8-bit heat-off threshold; heater turns off when the average is at or above it; T_OFF > T_ON is required.
REQ-003 Parameter MIN_ON, default 4: minimum dwell in ON, in clock cycles (1..255).
REQ-004 Parameter MIN_OFF, default 4: minimum dwell in OFF, in clock cycles (1..255).
REQ-005 Parameter MAX_DIFF, default 10: maximum allowed |ts1 - ts2| before a sample counts as bad (0..255).
REQ-006 Parameter FAULT_CNT, default 3: consecutive bad or good samples needed to enter or leave FAULT (1..15).
REQ-007 clk  input  1: single clock; all state updates on its rising edge.
REQ-008 rst  input  1: synchronous, active-high reset.
REQ-009 ts1  input  8: signed two's-complement temperature, sensor 1.
REQ-010 ts2  input  8: signed two's-complement temperature, sensor 2.
REQ-011 out  output 1: heater enable, registered; 1 = heat.

Function
REQ-012 Inputs are sampled on every rising edge; out SHALL be 1 exactly when the state register is ON (no combinational path from ts1/ts2 to out).
REQ-013 avg = (ts1 + ts2) >>> 1, computed as a 9-bit signed sum with arithmetic shift (floors toward minus infinity: -5 + -4 gives -5); no overflow at any input pair.
REQ-014 States: OFF, ON, FAULT (FAULT only with the macro); dwell counter, 8-bit saturating, cleared on every state entry, incremented on each edge spent in the state.
REQ-015 OFF to ON: on an edge where avg < T_ON and dwell >= MIN_OFF (pre-edge value).
REQ-016 ON to OFF: on an edge where avg >= T_OFF and dwell >= MIN_ON.
REQ-017 T_ON <= avg < T_OFF: hold the current state (hysteresis band).
REQ-018 Threshold crossings during the minimum dwell SHALL be ignored, not queued; they are re-evaluated each edge.
REQ-019 A sample is bad if |ts1 - ts2| > MAX_DIFF (difference computed in 9 bits), or if either input equals -128 (8'h80, sensor-invalid code).
REQ-020 Bad counter: increments on a bad sample, clears on a good sample. On the FAULT_CNT-th consecutive bad sample edge, go to FAULT from either OFF or ON; this takes priority over REQ-015 and REQ-016.
REQ-021 In FAULT, out = 0; the good counter counts consecutive good samples; on the FAULT_CNT-th consecutive good edge, go to OFF with dwell cleared.

Reset
REQ-022 rst high at a rising edge sets state to OFF, out to 0, dwell to 0, and both fault counters to 0; rst overrides all other conditions, including mid-dwell and in FAULT.
REQ-023 Before the first reset, out is undefined; no power-on value is guaranteed.

Configuration
REQ-024 Macro HC_FAULT_DETECT_EN defined: REQ-019 to REQ-021 are implemented, including the FAULT state.
REQ-025 Macro HC_FAULT_DETECT_EN undefined: no FAULT state and no fault counters; out depends only on avg and dwell; -128 is treated as an ordinary temperature.

Verification
REQ-026 Reset, then ts1 = ts2 = -5 held (avg -5): out = 0 for edges 1-4 after reset release and rises at edge 5; out stays 1.
REQ-027 From ON, set ts1 = ts2 = 20 (band): out stays 1. Then set 22/22: out falls on the first edge with dwell >= 4. Then 20/20: out stays 0.
REQ-028 ON for 1 cycle, then avg = 30: out holds 1 until MIN_ON is satisfied, then falls.
REQ-029 With the macro: ts1 = 0, ts2 = 11 for 3 edges gives FAULT and out = 0 at edge 3; ts1 = 0, ts2 = 10 for 2 edges keeps FAULT; a third good edge gives OFF, then ON after MIN_OFF if avg < 18. ts1 = -128 behaves identically to a bad pair.
REQ-030 Without the macro: ts1 = 0, ts2 = 11 gives avg 5 and out follows REQ-015 with no fault.
REQ-031 Assert rst for 1 cycle while ON and in FAULT: out = 0 on that edge and dwell restarts.

Source files
------------

// File: rtl/hc.sv
// hc: two-sensor hysteresis heater controller.
// Averages two signed 8-bit temperatures and drives a registered heater enable.
// ON/OFF transitions use the T_ON/T_OFF hysteresis band and minimum dwell times.
// Optional sensor-fault detection is enabled by defining HC_FAULT_DETECT_EN.
// When enabled, the FAULT state, the sensor plausibility check and the bad/good
// run counters are built; otherwise out depends only on the average and dwell.
module hc #(
   parameter logic signed [7:0] T_ON      = 8'sd18,
   parameter logic signed [7:0] T_OFF     = 8'sd22,
   parameter logic [7:0]        MIN_ON    = 8'd4,
   parameter logic [7:0]        MIN_OFF   = 8'd4,
   parameter logic [7:0]        MAX_DIFF  = 8'd10,
   parameter logic [3:0]        FAULT_CNT = 4'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ts1,
   input  logic [7:0] ts2,
   output logic       out
);

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_ON    = 2'd1;
`ifdef HC_FAULT_DETECT_EN
   localparam logic [1:0] S_FAULT = 2'd2;
`endif

   localparam logic signed [8:0] TON9  = {T_ON[7], T_ON};
   localparam logic signed [8:0] TOFF9 = {T_OFF[7], T_OFF};

   // Reject parameter sets that break the hysteresis or dwell assumptions.
   if (T_OFF <= T_ON) begin : g_bad_thresholds
      $error("hc: T_OFF must be greater than T_ON");
   end
   if (MIN_ON == 8'd0 || MIN_OFF == 8'd0) begin : g_bad_dwell
      $error("hc: MIN_ON and MIN_OFF must be at least 1");
   end
   if (FAULT_CNT == 4'd0) begin : g_bad_fault_cnt
      $error("hc: FAULT_CNT must be at least 1");
   end
   if (MAX_DIFF > 8'd255) begin : g_bad_max_diff
      $error("hc: MAX_DIFF out of range");
   end

   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [7:0]        dwell;
   logic signed [8:0] sum;
   logic signed [8:0] avg;

   // 9-bit sum cannot overflow; the arithmetic shift floors toward minus infinity.
   assign sum = {ts1[7], ts1} + {ts2[7], ts2};
   assign avg = sum >>> 1;

   assign out = (state == S_ON);

`ifdef HC_FAULT_DETECT_EN
   logic signed [8:0] diff;
   logic [8:0]        mag;
   logic              bad;
   logic [3:0]        bad_cnt;
   logic [3:0]        good_cnt;

   assign diff = {ts1[7], ts1} - {ts2[7], ts2};
   assign mag  = diff[8] ? 9'(-diff) : 9'(diff);
   assign bad  = (mag > {1'b0, MAX_DIFF}) || (ts1 == 8'h80) || (ts2 == 8'h80);
`endif

   // Next-state selection: hysteresis with dwell gating, fault entry overrides it.
   always_comb begin
      state_nx = state;
      case (state)
         S_OFF:   if (avg < TON9 && dwell >= MIN_OFF) state_nx = S_ON;
         S_ON:    if (avg >= TOFF9 && dwell >= MIN_ON) state_nx = S_OFF;
`ifdef HC_FAULT_DETECT_EN
         S_FAULT: if (!bad && good_cnt >= FAULT_CNT - 4'd1) state_nx = S_OFF;
`endif
         default: state_nx = S_OFF;
      endcase
`ifdef HC_FAULT_DETECT_EN
      if (state != S_FAULT && bad && bad_cnt >= FAULT_CNT - 4'd1) state_nx = S_FAULT;
`endif
   end

   // State register and saturating dwell counter, cleared on every state entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_OFF;
         dwell <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state)
            dwell <= '0;
         else if (dwell != 8'hFF)
            dwell <= dwell + 8'd1;
      end
   end

`ifdef HC_FAULT_DETECT_EN
   // Consecutive bad-sample run and, while staying in FAULT, consecutive good run.
   always_ff @(posedge clk) begin
      if (rst) begin
         bad_cnt  <= '0;
         good_cnt <= '0;
      end else begin
         if (!bad)
            bad_cnt <= '0;
         else if (bad_cnt != 4'hF)
            bad_cnt <= bad_cnt + 4'd1;

         if (state == S_FAULT && state_nx == S_FAULT && !bad && good_cnt != 4'hF)
            good_cnt <= good_cnt + 4'd1;
         else if (!(state == S_FAULT && state_nx == S_FAULT && !bad))
            good_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_hc.sv
// tb_hc: scoreboard bench for hc with directed scenarios and random stimulus.
// The stimulus process updates a behavioural model each edge and queues the
// expected heater output; a separate monitor pops and compares after each edge.
module tb_hc;

   localparam int TON  = 18;
   localparam int TOFF = 22;
   localparam int MON  = 4;
   localparam int MOFF = 4;
   localparam int MAXD = 10;
   localparam int FC   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ts1 = '0;
   logic [7:0] ts2 = '0;
   logic       out;

   typedef struct {
      int   idx;
      logic exp;
   } exp_t;

   exp_t expq[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   nstep      = 0;

   // Model state: 0 = off, 1 = heating, 2 = sensor fault.
   int   m_mode    = 0;
   int   m_dwell   = 0;
   int   m_badrun  = 0;
   int   m_goodrun = 0;

   hc #(
      .T_ON(8'sd18), .T_OFF(8'sd22), .MIN_ON(8'd4), .MIN_OFF(8'd4),
      .MAX_DIFF(8'd10), .FAULT_CNT(4'd3)
   ) dut (
      .clk(clk), .rst(rst), .ts1(ts1), .ts2(ts2), .out(out)
   );

   always #5 clk = ~clk;

   function automatic int floor_half(input int s);
      if (s < 0 && (s % 2) != 0) return s / 2 - 1;
      return s / 2;
   endfunction

   // Apply one sample over one rising edge and queue the model's expected out.
   task automatic step(input logic r, input int a, input int b);
      int  avg;
      int  d;
      int  next_mode;
      bit  bad;
      @(negedge clk);
      rst = r;
      ts1 = 8'(a);
      ts2 = 8'(b);
      @(posedge clk);
      avg = floor_half(a + b);
      d   = (a > b) ? a - b : b - a;
`ifdef HC_FAULT_DETECT_EN
      bad = (d > MAXD) || (a == -128) || (b == -128);
`else
      bad = 1'b0;
`endif
      if (r) begin
         m_mode = 0; m_dwell = 0; m_badrun = 0; m_goodrun = 0;
      end else begin
         next_mode = m_mode;
         m_badrun  = bad ? m_badrun + 1 : 0;
         if (m_mode == 2) begin
            m_goodrun = bad ? 0 : m_goodrun + 1;
            if (m_goodrun >= FC) next_mode = 0;
         end else if (bad && m_badrun >= FC) begin
            next_mode = 2;
            m_goodrun = 0;
         end else if (m_mode == 0 && avg < TON && m_dwell >= MOFF) begin
            next_mode = 1;
         end else if (m_mode == 1 && avg >= TOFF && m_dwell >= MON) begin
            next_mode = 0;
         end
         m_dwell = (next_mode != m_mode) ? 0 : m_dwell + 1;
         m_mode  = next_mode;
      end
      nstep++;
      expq.push_back('{idx: nstep, exp: (m_mode == 1)});
   endtask

   task automatic hold(input int n, input int a, input int b);
      for (int i = 0; i < n; i++) step(1'b0, a, b);
   endtask

   // Monitor: compare one queued expectation per edge, sampled 1 time unit later.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            compared++;
            if (out !== e.exp) begin
               mismatched++;
               $display("FAIL out step %0d: got %b expected %b (ts1=%0d ts2=%0d rst=%b)",
                        e.idx, out, e.exp, $signed(ts1), $signed(ts2), rst);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int a;
      int b;
      int k;
      // Reset, cold hold: heater rises on the fifth edge after release.
      step(1'b1, -5, -5);
      hold(8, -5, -5);
      // Hysteresis band, then hot, then band again.
      hold(6, 20, 20);
      hold(6, 22, 22);
      hold(4, 20, 20);
      // Heat on, then immediately too hot: minimum on-time holds the heater.
      hold(1, 0, 0);
      hold(8, 30, 30);
      // Reset while heating.
      hold(6, 0, 0);
      step(1'b1, 0, 0);
      hold(6, 0, 0);
      // Sensor disagreement, recovery, and the invalid code.
      hold(3, 0, 11);
      hold(2, 0, 10);
      hold(1, 0, 10);
      hold(6, 0, 10);
      hold(3, -128, 0);
      hold(2, 5, 5);
      step(1'b1, 5, 5);
      hold(3, 0, 11);
      step(1'b1, 0, 11);
      hold(6, 0, 0);
      // Full-range extremes for the average.
      hold(6, 127, 127);
      hold(6, -128, -128);
      hold(6, -5, -4);
      hold(6, 127, -128);
      // Randomized phase around the thresholds, with faults and resets.
      for (int i = 0; i < 800; i++) begin
         k = int'($urandom_range(0, 99));
         if (k < 3) begin
            step(1'b1, 0, 0);
         end else begin
            if (k < 12) begin
               a = int'($urandom_range(0, 255)) - 128;
               b = int'($urandom_range(0, 255)) - 128;
            end else if (k < 16) begin
               a = -128;
               b = int'($urandom_range(0, 40)) - 5;
            end else begin
               a = int'($urandom_range(0, 40)) - 5;
               b = a + int'($urandom_range(0, 24)) - 12;
            end
            hold(int'($urandom_range(1, 6)), a, b);
         end
      end
      @(posedge clk);
      #3;
      if (expq.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, required 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
